// File: rtl/serial_word_tx_if.sv
// Word-in/bit-out handshake bundle for serial_word_tx.
// master = word producer and serial consumer; slave = the framer.
interface serial_word_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sout;
    logic             sout_valid;
    logic             frame_done;

    modport master (
        output din, din_valid,
        input  din_ready, sout, sout_valid, frame_done
    );

    modport slave (
        input  din, din_valid,
        output din_ready, sout, sout_valid, frame_done
    );
endinterface

// File: rtl/serial_word_tx.sv
// Parallel-in/serial-out framer; sout idles high between frames.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit to every frame.
module serial_word_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b0
) (
    input logic              clk,
    input logic              rst,
    serial_word_tx_if.slave  bus
);
    localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
`ifndef SERIAL_TX_PARITY_EN
    localparam logic [CntW-1:0] PenultCnt = CntW'(WIDTH - 2);
`endif

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
    typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

    state_e           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CntW-1:0]  cnt_q;
    logic             sout_q;
    logic             sout_valid_q;
    logic             frame_done_q;
`ifdef SERIAL_TX_PARITY_EN
    logic             parity_q;
`endif

    logic             last_data;
    logic             ready;
    logic             xfer;
    logic             din_first;
    logic             next_bit;
    logic [WIDTH-1:0] din_rest;
    logic [WIDTH-1:0] shreg_rest;

    assign last_data = (state_q == StShift) && (cnt_q == LastCnt);

`ifdef SERIAL_TX_PARITY_EN
    assign ready = (state_q == StIdle) || (state_q == StParity);
`else
    assign ready = (state_q == StIdle) || last_data;
`endif

    assign xfer = bus.din_valid && ready;

    // Shift register holds the bits still to be sent, next one at the output end.
    assign din_first  = LSB_FIRST ? bus.din[0] : bus.din[WIDTH-1];
    assign din_rest   = LSB_FIRST ? (bus.din >> 1) : (bus.din << 1);
    assign next_bit   = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
    assign shreg_rest = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            shreg_q      <= '0;
            cnt_q        <= '0;
            sout_q       <= 1'b1;
            sout_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else if (xfer) begin
            state_q      <= StShift;
            shreg_q      <= din_rest;
            cnt_q        <= '0;
            sout_q       <= din_first;
            sout_valid_q <= 1'b1;
            frame_done_q <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q     <= ^bus.din;
`endif
        end else begin
            unique case (state_q)
                StShift: begin
                    if (!last_data) begin
                        cnt_q   <= cnt_q + CntW'(1);
                        shreg_q <= shreg_rest;
                        sout_q  <= next_bit;
`ifdef SERIAL_TX_PARITY_EN
                        frame_done_q <= 1'b0;
`else
                        frame_done_q <= (cnt_q == PenultCnt);
`endif
                    end else begin
`ifdef SERIAL_TX_PARITY_EN
                        state_q      <= StParity;
                        sout_q       <= parity_q;
                        frame_done_q <= 1'b1;
`else
                        state_q      <= StIdle;
                        sout_q       <= 1'b1;
                        sout_valid_q <= 1'b0;
                        frame_done_q <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q      <= StIdle;
                    sout_q       <= 1'b1;
                    sout_valid_q <= 1'b0;
                    frame_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.din_ready  = ready;
    assign bus.sout       = sout_q;
    assign bus.sout_valid = sout_valid_q;
    assign bus.frame_done = frame_done_q;
endmodule
